// File: rtl/mem_responder_16b_if.sv
// Request and response stream pair between a memory client (master) and
// the 16-byte-line memory responder (slave).
interface mem_responder_16b_if;
  // {type[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
  logic [174:0] mem_reqstream_msg;
  logic         mem_reqstream_val;
  logic         mem_reqstream_rdy;
  // {type[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
  logic [144:0] mem_respstream_msg;
  logic         mem_respstream_val;
  logic         mem_respstream_rdy;

  modport master (
    output mem_reqstream_msg,
    output mem_reqstream_val,
    input  mem_reqstream_rdy,
    input  mem_respstream_msg,
    input  mem_respstream_val,
    output mem_respstream_rdy
  );

  modport slave (
    input  mem_reqstream_msg,
    input  mem_reqstream_val,
    output mem_reqstream_rdy,
    output mem_respstream_msg,
    output mem_respstream_val,
    input  mem_respstream_rdy
  );
endinterface

// File: rtl/mem_responder_16b.sv
// Single-port memory responder: accesses a line array in the accept cycle and
// returns responses in order, no earlier than LATENCY cycles later, via a bounded queue.
module mem_responder_16b #(
  parameter int unsigned NUM_LINES   = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  mem_responder_16b_if.slave bus
);
  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned PtrW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned WaitW = $clog2(LATENCY) + 1;

  typedef struct packed {
    logic [2:0]   mtype;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } req_t;

  typedef struct packed {
    logic [2:0]   mtype;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } resp_t;

  logic [127:0]     r_mem [NUM_LINES];
  resp_t            r_q_msg [QUEUE_DEPTH];
  logic [WaitW-1:0] r_q_wait [QUEUE_DEPTH];
  logic [PtrW-1:0]  r_head;
  logic [PtrW-1:0]  r_tail;
  logic [CntW-1:0]  r_count;

  req_t             w_req;
  resp_t            w_resp;
  logic             w_rdy;
  logic             w_val;
  logic             w_acc;
  logic             w_deq;
  logic             w_is_wr;
  logic [IdxW-1:0]  w_idx;
  logic [6:0]       w_shift;
  logic [127:0]     w_line;
  logic [127:0]     w_nmask;
  logic [127:0]     w_wr_mask;
  logic [127:0]     w_wr_line;
  logic [127:0]     w_rd_data;
  logic             w_unused_addr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_req         = bus.mem_reqstream_msg;
  assign w_unused_addr = ^w_req.addr[31:4+IdxW];

  // Occupancy counts both in-flight and waiting responses; no path from req val.
  assign w_rdy = !reset && (r_count < CntW'(QUEUE_DEPTH));
  assign w_val = !reset && (r_count != '0) && (r_q_wait[r_head] == '0);
  assign w_acc = bus.mem_reqstream_val && w_rdy;
  assign w_deq = w_val && bus.mem_respstream_rdy;

  assign bus.mem_reqstream_rdy  = w_rdy;
  assign bus.mem_respstream_val = w_val;
  assign bus.mem_respstream_msg = w_val ? r_q_msg[r_head] : '0;

  always_comb begin
    w_idx   = w_req.addr[4 +: IdxW];
    w_shift = {w_req.addr[3:0], 3'b000};
    w_line  = r_mem[w_idx];
    w_nmask = '0;
    for (int i = 0; i < 16; i++) begin
      if ((w_req.len == 4'd0) || (i < int'(w_req.len))) begin
        w_nmask[i*8 +: 8] = 8'hff;
      end
    end
    // Shifting past bit 127 naturally drops bytes beyond the end of the line.
    w_rd_data = (w_line >> w_shift) & w_nmask;
    w_wr_mask = w_nmask << w_shift;
    w_wr_line = (w_line & ~w_wr_mask) | ((w_req.data << w_shift) & w_wr_mask);
    w_is_wr   = (w_req.mtype == 3'd1) || (w_req.mtype == 3'd2);

    w_resp        = '0;
    w_resp.mtype  = w_req.mtype;
    w_resp.opaque = w_req.opaque;
    w_resp.len    = w_req.len;
    w_resp.data   = (w_req.mtype == 3'd0) ? w_rd_data : '0;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_acc && w_is_wr) begin
      r_mem[w_idx] <= w_wr_line;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_acc) r_tail <= ptr_inc(r_tail);
      if (w_deq) r_head <= ptr_inc(r_head);
      r_count <= r_count + CntW'(w_acc) - CntW'(w_deq);
    end
  end

  // Each entry counts down to zero; the head may only be presented once it reaches zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
      if (r_q_wait[i] != '0) r_q_wait[i] <= r_q_wait[i] - 1'b1;
    end
    if (w_acc) begin
      r_q_msg[r_tail]  <= w_resp;
      r_q_wait[r_tail] <= WaitW'(LATENCY - 1);
    end
  end
endmodule

// File: tb/tb_mem_responder_16b.sv
// Bench for mem_responder_16b: directed scenarios plus random traffic, checked every
// cycle against a byte-array memory and a due-time ordered response queue.
module tb_mem_responder_16b;
  localparam int LAT = 2;
  localparam int QD  = 3;

  typedef struct packed {
    logic [2:0]   mtype;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } req_t;

  typedef struct packed {
    logic [2:0]   mtype;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } resp_t;

  typedef struct {
    int    due;
    resp_t msg;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_responder_16b_if bus ();

  mem_responder_16b #(
    .NUM_LINES   (256),
    .LATENCY     (LAT),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem_m [256][16];
  exp_t       exp_q [$];
  logic [7:0] opq_log [$];
  resp_t      last_resp;
  logic       acc_last;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  function automatic req_t mk(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                              input logic [3:0] l, input logic [127:0] d);
    req_t r;
    r.mtype = t; r.opaque = o; r.addr = a; r.len = l; r.data = d;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural memory: byte-granular access straight from the addressing rules.
  task automatic model_exec(input req_t r, output resp_t p);
    int off, idx, n;
    off = int'(r.addr[3:0]);
    idx = int'(r.addr[11:4]);
    n   = (r.len == 4'd0) ? 16 : int'(r.len);
    p = '0;
    p.mtype = r.mtype; p.opaque = r.opaque; p.len = r.len;
    for (int k = 0; k < n; k++) begin
      if (off + k < 16) begin
        if (r.mtype == 3'd0) p.data[k*8 +: 8] = mem_m[idx][off+k];
        else if (r.mtype == 3'd1 || r.mtype == 3'd2) mem_m[idx][off+k] = r.data[k*8 +: 8];
      end
    end
  endtask

  task automatic tick(input logic rv, input req_t rq, input logic prdy);
    logic  e_rdy, e_val;
    resp_t e_msg, got, m;
    exp_t  e;
    bus.mem_reqstream_val  = rv;
    bus.mem_reqstream_msg  = rq;
    bus.mem_respstream_rdy = prdy;
    #1;
    e_rdy = !reset && (exp_q.size() < QD);
    e_val = !reset && (exp_q.size() != 0) && (exp_q[0].due <= cyc);
    e_msg = e_val ? exp_q[0].msg : '0;
    got   = bus.mem_respstream_msg;
    total++;
    assert (bus.mem_reqstream_rdy === e_rdy) else begin
      bad++; $error("FAIL req_rdy cyc=%0d got=%b exp=%b", cyc, bus.mem_reqstream_rdy, e_rdy);
    end
    total++;
    assert (bus.mem_respstream_val === e_val) else begin
      bad++; $error("FAIL resp_val cyc=%0d got=%b exp=%b", cyc, bus.mem_respstream_val, e_val);
    end
    total++;
    assert (got === e_msg) else begin
      bad++; $error("FAIL resp_msg cyc=%0d got=%h exp=%h", cyc, got, e_msg);
    end
    acc_last = rv && bus.mem_reqstream_rdy;
    if (e_val && prdy) begin
      last_resp = got;
      opq_log.push_back(got.opaque);
      void'(exp_q.pop_front());
    end
    if (reset) begin
      exp_q.delete();
    end else if (rv && e_rdy) begin
      model_exec(rq, m);
      e.due = cyc + LAT;
      e.msg = m;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1'b0, '0, 1'b1);
  endtask

  task automatic check128(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [127:0] k1, k2;
    int           acc;
    logic [31:0]  a;
    int           sel;
    logic [2:0]   t;
    k1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    // Reset state, then ready the cycle after release.
    repeat (3) tick(1'b0, '0, 1'b0);
    reset = 1'b0;
    tick(1'b0, '0, 1'b1);

    // Give every line used below known contents.
    for (int i = 0; i < 48; i++) tick(1'b1, mk(3'd1, 8'(i), 32'(i) << 4, 4'd0, rnd128()), 1'b1);
    drain();

    // Full-line write then read back.
    tick(1'b1, mk(3'd1, 8'h11, 32'h100, 4'd0, k1), 1'b1);
    tick(1'b1, mk(3'd0, 8'h12, 32'h100, 4'd0, '0), 1'b1);
    drain();
    check128("full_line_read", last_resp.data, k1);

    // Single byte write, then a 4-byte read straddling it.
    tick(1'b1, mk(3'd1, 8'h21, 32'h105, 4'd1, 128'hAA), 1'b1);
    tick(1'b1, mk(3'd0, 8'h22, 32'h104, 4'd4, '0), 1'b1);
    drain();
    check128("byte_write_read", last_resp.data, 128'h89ABAAEF);

    // Write running off the end of the line keeps only bytes 14..15.
    k2 = rnd128();
    tick(1'b1, mk(3'd2, 8'h31, 32'h200, 4'd0, k2), 1'b1);
    tick(1'b1, mk(3'd1, 8'h32, 32'h20E, 4'd4, 128'h11223344), 1'b1);
    tick(1'b1, mk(3'd0, 8'h33, 32'h200, 4'd0, '0), 1'b1);
    drain();
    check128("line_end_write", last_resp.data, {16'h3344, k2[111:0]});

    // Back-to-back reads at full throughput.
    opq_log.delete();
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, mk(3'd0, 8'(i), 32'(i) << 4, 4'd0, '0), 1'b1);
      acc += int'(acc_last);
    end
    check128("b2b_accepts", 128'(acc), 128'd4);
    drain();
    check128("b2b_order", {96'(opq_log.size()), opq_log[0], opq_log[1], opq_log[2], opq_log[3]},
             {96'd4, 32'h00010203});

    // Backpressure: only QD requests fit while the consumer stalls.
    opq_log.delete();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, mk(3'd0, 8'h40 + 8'(acc), 32'h100, 4'd0, '0), 1'b0);
      acc += int'(acc_last);
    end
    check128("bp_accepts", 128'(acc), 128'(QD));
    drain();
    check128("bp_order", {104'(opq_log.size()), opq_log[0], opq_log[1], opq_log[2]},
             {104'd3, 24'h404142});

    // Reset with two reads in flight; nothing may emerge afterwards.
    tick(1'b1, mk(3'd0, 8'h51, 32'h100, 4'd0, '0), 1'b1);
    tick(1'b1, mk(3'd0, 8'h52, 32'h100, 4'd0, '0), 1'b1);
    reset = 1'b1;
    tick(1'b0, '0, 1'b1);
    reset = 1'b0;
    repeat (4) tick(1'b0, '0, 1'b1);
    tick(1'b1, mk(3'd0, 8'h53, 32'h100, 4'd0, '0), 1'b1);
    drain();
    check128("post_reset_read", last_resp.data, 128'hDEADBEEF_01234567_89ABAAEF_CAFEF00D);

    // Random traffic with random consumer backpressure and aliased upper address bits.
    for (int i = 0; i < 400; i++) begin
      a = $urandom();
      a[11:4] = 8'($urandom_range(0, 47));
      sel = $urandom_range(0, 9);
      t = (sel < 4) ? 3'd0 : (sel < 7) ? 3'd1 : (sel < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      tick(1'($urandom_range(0, 1)), mk(t, 8'($urandom()), a, 4'($urandom()), rnd128()),
           1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
